// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the MIPS fetch stage
//
// Purpose : fetch FSM state encoding, decoder opcode constants, default
//           reset PC and fetch timeout, and the PC-relative / jump target
//           helpers used by the next-PC selector.
// Ports   : none (package).
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
   localparam logic [7:0]  DEF_IMEM_TIMEOUT = 8'd255;

   // Sign-extended 16-bit branch immediate, scaled to a byte offset.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   // J-format target: upper nibble of the sequential PC, word index below.
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [25:0] idx);
      return {pc_plus4[31:28], idx, 2'b00};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC selector for the fetch stage
//
// Purpose : choose the PC of the instruction after inst.
//           Priority: jr -> jr_target (only with IF_JR_EN),
//                     jump -> {pc_plus4[31:28], inst[25:0], 2'b00},
//                     branch && zero -> pc_plus4 + sext(inst[15:0]) << 2,
//                     otherwise pc_plus4.
//           Bits [1:0] of the result are always zero. Arithmetic wraps mod 2^32.
// Config  : IF_JR_EN adds the jr / jr_target inputs.
// Ports   :
//   pc_plus4   in  32  address of inst + 4
//   inst       in  32  instruction being retired
//   branch     in   1  decoder Branch
//   zero       in   1  ALU Zero
//   jump       in   1  decoder Jump
//   jr         in   1  jump-register select (IF_JR_EN only)
//   jr_target  in  32  rs value for jr (IF_JR_EN only)
//   next_pc    out 32  selected next PC, word aligned
module npc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] inst,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
`ifdef IF_JR_EN
   input  logic        jr,
   input  logic [31:0] jr_target,
`endif
   output logic [31:0] next_pc
);

   logic [31:0] npc_raw;

   // The opcode field is decoded upstream; only the immediate and target
   // fields matter here.
   logic unused_opcode;
   assign unused_opcode = ^inst[31:26];

   // Later assignments override earlier ones, so the list below runs from
   // lowest to highest priority.
   always_comb begin
      npc_raw = pc_plus4;
      if (branch && zero) begin
         npc_raw = pc_plus4 + branch_offset(inst[15:0]);
      end
      if (jump) begin
         npc_raw = jump_target(pc_plus4, inst[25:0]);
      end
`ifdef IF_JR_EN
      if (jr) begin
         npc_raw = jr_target;
      end
`endif
   end

   // A misaligned jr_target must never reach imem_addr.
   assign next_pc = npc_raw & 32'hFFFF_FFFC;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS instruction-fetch stage with imem req/ack handshake
//
// Purpose : holds the PC, fetches the word at pc from instruction memory,
//           presents it to decode/datapath until retired, then advances pc
//           through npc_calc. A fetch that waits IMEM_TIMEOUT cycles for
//           imem_ack parks the stage in a sticky error state until rst.
// Config  : IF_JR_EN adds the jr / jr_target inputs (jump-register).
// Params  : RESET_PC      pc loaded on reset
//           IMEM_TIMEOUT  FETCH cycles without ack before fetch_err (8 bit)
// Ports   :
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   imem_req    out  1  fetch request
//   imem_addr   out 32  fetch address (= pc)
//   imem_ack    in   1  memory response valid
//   imem_rdata  in  32  instruction word, taken when imem_req && imem_ack
//   inst        out 32  registered instruction
//   inst_valid  out  1  inst is held for execution
//   pc          out 32  address of inst
//   pc_plus4    out 32  pc + 4
//   retire      in   1  datapath completed inst this cycle
//   stall       in   1  freeze: no new request, no retire
//   branch      in   1  decoder Branch
//   zero        in   1  ALU Zero
//   jump        in   1  decoder Jump
//   jr          in   1  jump-register select (IF_JR_EN only)
//   jr_target   in  32  rs value for jr (IF_JR_EN only)
//   fetch_err   out  1  sticky fetch timeout flag
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
   parameter logic [7:0]  IMEM_TIMEOUT = DEF_IMEM_TIMEOUT
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
`ifdef IF_JR_EN
   input  logic        jr,
   input  logic [31:0] jr_target,
`endif
   output logic        fetch_err
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic [7:0]   to_cnt_q, to_cnt_d;
   logic [31:0]  next_pc;

   assign pc_plus4 = pc_q + 32'd4;

   npc_calc u_npc_calc (
      .pc_plus4  (pc_plus4),
      .inst      (inst_q),
      .branch    (branch),
      .zero      (zero),
      .jump      (jump),
`ifdef IF_JR_EN
      .jr        (jr),
      .jr_target (jr_target),
`endif
      .next_pc   (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         inst_q   <= 32'd0;
         to_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      to_cnt_d = to_cnt_q;
      imem_req = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d  = ST_FETCH;
            to_cnt_d = 8'd0;
         end

         ST_FETCH: begin
            // Stall withdraws the request combinationally and freezes the
            // timeout, so a stalled cycle is never charged to the memory.
            if (!stall) begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  inst_d   = imem_rdata;
                  to_cnt_d = 8'd0;
                  state_d  = ST_HOLD;
               end else begin
                  to_cnt_d = to_cnt_q + 8'd1;
                  if (to_cnt_d == IMEM_TIMEOUT) begin
                     state_d = ST_ERR;
                  end
               end
            end
         end

         ST_HOLD: begin
            if (retire && !stall) begin
               pc_d     = next_pc;
               to_cnt_d = 8'd0;
               state_d  = ST_FETCH;
            end
         end

         ST_ERR: begin
            state_d = ST_ERR;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst       = inst_q;
   assign inst_valid = (state_q == ST_HOLD);
   assign fetch_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic        fetch_err;
`ifdef IF_JR_EN
   logic        jr;
   logic [31:0] jr_target;
`endif

   inst_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .retire     (retire),
      .stall      (stall),
      .branch     (branch),
      .zero       (zero),
      .jump       (jump),
`ifdef IF_JR_EN
      .jr         (jr),
      .jr_target  (jr_target),
`endif
      .fetch_err  (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int passed = 0;
   int total  = 0;

   logic [31:0] exp_addr_q[$];
   logic        mem_on;
   logic        force_ack;
   logic        pending;
   logic [31:0] last_addr;
   logic        in_fetch;
   logic        valid_prev;

   // Program image, hand-assembled.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h8C08_0004;  // lw
         32'h0000_0004: return 32'h0800_0004;  // j 0x10
         32'h0000_0010: return 32'h1000_FFFC;  // beq -4 words
         32'h0000_0014: return 32'h0800_0008;  // j 0x20
         32'h0000_0020: return 32'h0800_0040;  // j 0x100
         32'h0000_0100: return 32'h1000_FFBE;  // beq -0x42 words
         32'hFFFF_FFFC: return 32'h0000_0020;  // add
         default:       return 32'h0000_0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Memory: acknowledges a request one cycle after it is first seen.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      pending    = 1'b0;
      forever begin
         @(negedge clk);
         pending = imem_req && !imem_ack;
         @(posedge clk);
         #1;
         imem_ack   = (pending && mem_on) || force_ack;
         imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_word(imem_addr);
      end
   end

   // Monitor: new fetch -> compare address against scoreboard;
   // inst_valid rising -> compare pc and the held word.
   initial begin
      in_fetch   = 1'b0;
      valid_prev = 1'b0;
      last_addr  = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_fetch   = 1'b0;
            valid_prev = 1'b0;
         end else begin
            if (imem_req && !in_fetch) begin
               in_fetch = 1'b1;
               if (exp_addr_q.size() == 0) begin
                  total++;
                  $display("FAIL unexpected_fetch: addr %h, none expected", imem_addr);
               end else begin
                  last_addr = exp_addr_q.pop_front();
                  check("fetch_addr", imem_addr, last_addr);
               end
            end
            if (inst_valid && !valid_prev) begin
               in_fetch = 1'b0;
               check("hold_pc", pc, last_addr);
               check("hold_inst", inst, mem_word(last_addr));
            end
            valid_prev = inst_valid;
         end
      end
   end

   task automatic wait_valid(input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (inst_valid) found = 1'b1;
         else @(negedge clk);
      end
      if (!found) begin
         total++;
         $display("FAIL %s: inst_valid not seen within 50 cycles", name);
      end
   endtask

   task automatic do_retire(input string name, input logic br, input logic z,
                            input logic jmp, input logic [31:0] exp_next);
      wait_valid(name);
      branch = br;
      zero   = z;
      jump   = jmp;
      retire = 1'b1;
      exp_addr_q.push_back(exp_next);
      @(negedge clk);
      branch = 1'b0;
      zero   = 1'b0;
      jump   = 1'b0;
      retire = 1'b0;
      check({name, "_req_next_cycle"}, {31'd0, imem_req}, 32'd1);
      check({name, "_valid_dropped"}, {31'd0, inst_valid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      logic err_seen;
      rst       = 1'b1;
      retire    = 1'b0;
      stall     = 1'b0;
      branch    = 1'b0;
      zero      = 1'b0;
      jump      = 1'b0;
      mem_on    = 1'b1;
      force_ack = 1'b0;
`ifdef IF_JR_EN
      jr        = 1'b0;
      jr_target = 32'd0;
`endif
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_inst", inst, 32'h0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_err", {31'd0, fetch_err}, 32'd0);

      // Release: IDLE in cycle 1, request in cycle 2, ack cycle 3, valid cycle 4.
      exp_addr_q.push_back(32'h0);
      rst = 1'b0;
      #1 check("c1_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      check("c2_req", {31'd0, imem_req}, 32'd1);
      check("c2_addr", imem_addr, 32'h0);
      @(negedge clk);
      check("c3_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
      check("c4_valid", {31'd0, inst_valid}, 32'd1);

      do_retire("seq",           1'b0, 1'b0, 1'b0, 32'h0000_0004);
      do_retire("j_0x10",        1'b0, 1'b0, 1'b1, 32'h0000_0010);
      do_retire("beq_taken",     1'b1, 1'b1, 1'b0, 32'h0000_0004);
      do_retire("j_back",        1'b0, 1'b0, 1'b1, 32'h0000_0010);
      do_retire("beq_not_taken", 1'b1, 1'b0, 1'b0, 32'h0000_0014);

      // Stall in HOLD blocks retire.
      wait_valid("stall_hold");
      stall  = 1'b1;
      retire = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_hold_valid", {31'd0, inst_valid}, 32'd1);
         check("stall_hold_pc", pc, 32'h0000_0014);
         check("stall_hold_req", {31'd0, imem_req}, 32'd0);
      end
      stall  = 1'b0;
      retire = 1'b0;

      do_retire("j_0x20",   1'b0, 1'b0, 1'b1, 32'h0000_0020);
      do_retire("j_0x100",  1'b0, 1'b0, 1'b1, 32'h0000_0100);
      do_retire("beq_wrap", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
      wait_valid("wrap");
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      mem_on = 1'b0;
      do_retire("wrap_seq", 1'b0, 1'b0, 1'b0, 32'h0);

      // Stall in FETCH drops req at once; an ack while req=0 is ignored.
      stall     = 1'b1;
      force_ack = 1'b1;
      #1 check("stall_fetch_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      check("ack_no_req_ignored", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
      stall  = 1'b0;
      mem_on = 1'b1;
      wait_valid("lw_again");
      mem_on = 1'b0;
      do_retire("to_timeout", 1'b0, 1'b0, 1'b0, 32'h0000_0004);

      // Timeout: 255 requesting cycles; a 10-cycle stall in the middle
      // must not be counted.
      n        = 0;
      err_seen = 1'b0;
      for (int i = 0; i < 400 && !err_seen; i++) begin
         stall = (i >= 50 && i < 60);
         #1;
         if (fetch_err) err_seen = 1'b1;
         else if (imem_req) n++;
         @(negedge clk);
      end
      stall = 1'b0;
      check("timeout_reached", {31'd0, err_seen}, 32'd1);
      check("timeout_req_cycles", n, 32'd255);
      check("err_req", {31'd0, imem_req}, 32'd0);
      retire    = 1'b1;
      force_ack = 1'b1;
      repeat (3) @(negedge clk);
      retire    = 1'b0;
      force_ack = 1'b0;
      check("err_sticky", {31'd0, fetch_err}, 32'd1);
      check("err_no_valid", {31'd0, inst_valid}, 32'd0);
      check("err_req_still_low", {31'd0, imem_req}, 32'd0);

      // Asynchronous reset off the clock edge, then a late ack in IDLE.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_err", {31'd0, fetch_err}, 32'd0);
      check("arst_pc", pc, 32'h0);
      check("arst_inst", inst, 32'h0);
      check("arst_req", {31'd0, imem_req}, 32'd0);
      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_on = 1'b1;
      exp_addr_q.push_back(32'h0);
      rst       = 1'b0;
      force_ack = 1'b0;
      wait_valid("after_reset");
      check("after_reset_inst", inst, 32'h8C08_0004);
      check("sb_empty", exp_addr_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
